id_ex_stage: RTL and testbench

ID/EX pipeline stage of the MIPS core. It sits directly upstream of the ALU.
- Registers decoded operands and control each cycle.
- Forwards EX/MEM and MEM/WB results into the operands and selects the ALU In1/In2 sources.
- Drives the ALU 3-bit Ctrl, and detects load-use hazards so decode can stall.

---
 rtl/id_ex_if.sv | 70 +++++++
 rtl/id_ex_stage.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// ----------------------------------------------------------------------------
// id_ex_if : signal bundle between decode, the ID/EX stage and the ALU.
//
//   master : the decode/hazard side that drives id_*, flush, hold and the
//            EX/MEM and MEM/WB write-back snoop buses, and that observes the
//            ALU operands, EX controls and hazard_stall.
//   slave  : the id_ex_stage itself.
// ----------------------------------------------------------------------------
interface id_ex_if;
   // Decoded instruction from ID
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [31:0] id_imm;
   logic [4:0]  id_shamt;
   logic [2:0]  id_alu_ctrl;
   logic        id_alu_src;
   logic        id_uses_rt;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_mem_write;
   logic        id_mem_to_reg;
   // Pipeline control
   logic        flush;
   logic        hold;
   // Later-stage writers
   logic        exmem_reg_write;
   logic [4:0]  exmem_rd;
   logic [31:0] exmem_result;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_result;
   // EX-side outputs
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [2:0]  alu_ctrl;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd;
   logic        ex_valid;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_mem_to_reg;
   logic        hazard_stall;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
             id_shamt, id_alu_ctrl, id_alu_src, id_uses_rt, id_reg_write,
             id_mem_read, id_mem_write, id_mem_to_reg, flush, hold,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      input  alu_in1, alu_in2, alu_ctrl, ex_store_data, ex_rd, ex_valid,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
             hazard_stall
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
             id_shamt, id_alu_ctrl, id_alu_src, id_uses_rt, id_reg_write,
             id_mem_read, id_mem_write, id_mem_to_reg, flush, hold,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      output alu_in1, alu_in2, alu_ctrl, ex_store_data, ex_rd, ex_valid,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
             hazard_stall
   );
endinterface

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register of the MIPS core, directly feeding
// the ALU.
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (stage becomes a bubble)
//   bus   : id_ex_if.slave - decoded instruction, flush/hold, EX/MEM and
//           MEM/WB writer snoop buses in; ALU operands/ctrl, EX controls,
//           store data and hazard_stall out.
//
// Configuration
//   ID_EX_FWD_EN defined   : EX/MEM + MEM/WB forwarding into the operands,
//                            capture-time WB bypass, load-use stall only.
//   ID_EX_FWD_EN undefined : operands come only from stored data; decode is
//                            stalled on any RAW against a writer in EX, MEM
//                            or WB.
// ----------------------------------------------------------------------------
module id_ex_stage (
   input  logic   clk,
   input  logic   rst_n,
   id_ex_if.slave bus
);
   localparam logic [2:0] CTRL_LW  = 3'b001;
   localparam logic [2:0] CTRL_SW  = 3'b010;
   localparam logic [2:0] CTRL_SLL = 3'b101;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        alu_src;
      logic [2:0]  ctrl;
      logic [4:0]  rd;
`ifdef ID_EX_FWD_EN
      logic [4:0]  rs;
      logic [4:0]  rt;
`endif
      logic [4:0]  shamt;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
   } ex_state_t;

   localparam ex_state_t BUBBLE = {$bits(ex_state_t){1'b0}};

   // A writer matches an index only if it writes and is not register 0.
   function automatic logic reg_hit(input logic we, input logic [4:0] wrd,
                                    input logic [4:0] idx);
      return we & (wrd != 5'd0) & (wrd == idx);
   endfunction

   ex_state_t   state_q, state_d, cap_s;
   logic        hazard_s;
   logic [31:0] fwd_a_s, fwd_b_s;

`ifdef ID_EX_FWD_EN
   // Only a load still in EX cannot be forwarded in time.
   assign hazard_s = rst_n & ~bus.flush & bus.id_valid & state_q.valid &
                     state_q.mem_read & (state_q.rd != 5'd0) &
                     ((state_q.rd == bus.id_rs) |
                      (bus.id_uses_rt & (state_q.rd == bus.id_rt)));
`else
   // Without forwarding every in-flight writer of a source must drain first.
   assign hazard_s = rst_n & ~bus.flush & bus.id_valid & (
         reg_hit(state_q.valid & state_q.reg_write, state_q.rd, bus.id_rs) |
         reg_hit(bus.exmem_reg_write, bus.exmem_rd, bus.id_rs) |
         reg_hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rs) |
         (bus.id_uses_rt & (
            reg_hit(state_q.valid & state_q.reg_write, state_q.rd, bus.id_rt) |
            reg_hit(bus.exmem_reg_write, bus.exmem_rd, bus.id_rt) |
            reg_hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rt))));
`endif

   // Build the captured image of the decoded instruction.
   always_comb begin
      cap_s            = BUBBLE;
      cap_s.valid      = 1'b1;
      cap_s.reg_write  = bus.id_reg_write;
      cap_s.mem_read   = bus.id_mem_read;
      cap_s.mem_write  = bus.id_mem_write;
      cap_s.mem_to_reg = bus.id_mem_to_reg;
      cap_s.alu_src    = bus.id_alu_src;
      cap_s.rd         = bus.id_rd;
      cap_s.shamt      = bus.id_shamt;
      cap_s.imm        = bus.id_imm;
      // The ALU has no 010 decode; sw address generation is an add like lw.
      if (bus.id_alu_ctrl == CTRL_SW) begin
         cap_s.ctrl = CTRL_LW;
      end else begin
         cap_s.ctrl = bus.id_alu_ctrl;
      end
`ifdef ID_EX_FWD_EN
      cap_s.rs = bus.id_rs;
      cap_s.rt = bus.id_rt;
      // WB writes the register file this same cycle; take the value now.
      if (reg_hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rs)) begin
         cap_s.rs_data = bus.memwb_result;
      end else begin
         cap_s.rs_data = bus.id_rs_data;
      end
      if (reg_hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rt)) begin
         cap_s.rt_data = bus.memwb_result;
      end else begin
         cap_s.rt_data = bus.id_rt_data;
      end
`else
      cap_s.rs_data = bus.id_rs_data;
      cap_s.rt_data = bus.id_rt_data;
`endif
   end

   // Next-state selection: hold > flush/stall > capture > bubble.
   always_comb begin
      state_d = state_q;
      if (bus.hold) begin
         state_d = state_q;
      end else if (bus.flush | hazard_s) begin
         state_d = BUBBLE;
      end else if (bus.id_valid) begin
         state_d = cap_s;
      end else begin
         state_d = BUBBLE;
      end
   end

   // Stage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BUBBLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand forwarding: EX/MEM beats MEM/WB beats stored data.
   always_comb begin
`ifdef ID_EX_FWD_EN
      if (reg_hit(bus.exmem_reg_write, bus.exmem_rd, state_q.rs)) begin
         fwd_a_s = bus.exmem_result;
      end else if (reg_hit(bus.memwb_reg_write, bus.memwb_rd, state_q.rs)) begin
         fwd_a_s = bus.memwb_result;
      end else begin
         fwd_a_s = state_q.rs_data;
      end
      if (reg_hit(bus.exmem_reg_write, bus.exmem_rd, state_q.rt)) begin
         fwd_b_s = bus.exmem_result;
      end else if (reg_hit(bus.memwb_reg_write, bus.memwb_rd, state_q.rt)) begin
         fwd_b_s = bus.memwb_result;
      end else begin
         fwd_b_s = state_q.rt_data;
      end
`else
      fwd_a_s = state_q.rs_data;
      fwd_b_s = state_q.rt_data;
`endif
   end

   // ALU operand select; sll shifts rt by the stored shamt.
   always_comb begin
      if (state_q.ctrl == CTRL_SLL) begin
         bus.alu_in1 = fwd_b_s;
         bus.alu_in2 = {27'd0, state_q.shamt};
      end else if (state_q.alu_src) begin
         bus.alu_in1 = fwd_a_s;
         bus.alu_in2 = state_q.imm;
      end else begin
         bus.alu_in1 = fwd_a_s;
         bus.alu_in2 = fwd_b_s;
      end
   end

   assign bus.alu_ctrl      = state_q.ctrl;
   assign bus.ex_store_data = fwd_b_s;
   assign bus.ex_rd         = state_q.rd;
   assign bus.ex_valid      = state_q.valid;
   assign bus.ex_reg_write  = state_q.reg_write;
   assign bus.ex_mem_read   = state_q.mem_read;
   assign bus.ex_mem_write  = state_q.mem_write;
   assign bus.ex_mem_to_reg = state_q.mem_to_reg;
   assign bus.hazard_stall  = hazard_s;
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   id_ex_if bus ();
   id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic        valid, rw, mr, mw, m2r, alu_src;
      logic [2:0]  ctrl;
      logic [4:0]  rd, rs, rt, shamt;
      logic [31:0] rs_data, rt_data, imm;
   } ent_t;

   ent_t cur;
   ent_t bubble_e;
   ent_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic set_id(input logic v, input logic [2:0] ctrl,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                         input logic [4:0] sh, input logic src, input logic ut,
                         input logic rw, input logic mr, input logic mw, input logic m2r);
      bus.id_valid = v;     bus.id_alu_ctrl = ctrl;
      bus.id_rs = rs;       bus.id_rt = rt;       bus.id_rd = rd;
      bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
      bus.id_shamt = sh;    bus.id_alu_src = src; bus.id_uses_rt = ut;
      bus.id_reg_write = rw; bus.id_mem_read = mr;
      bus.id_mem_write = mw; bus.id_mem_to_reg = m2r;
   endtask

   task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                          input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
      bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
      bus.memwb_reg_write = ww; bus.memwb_rd = wrd; bus.memwb_result = wres;
   endtask

   function automatic logic hit(input logic we, input logic [4:0] wrd, input logic [4:0] idx);
      return we && (wrd != 5'd0) && (wrd == idx);
   endfunction

   // Reference stall decision from the current model EX contents.
   function automatic logic exp_stall();
      logic s;
      logic [4:0] rt_eff;
      rt_eff = bus.id_uses_rt ? bus.id_rt : 5'd0;
`ifdef ID_EX_FWD_EN
      s = bus.id_valid && cur.valid && cur.mr &&
          (hit(1'b1, cur.rd, bus.id_rs) || hit(1'b1, cur.rd, rt_eff));
`else
      s = bus.id_valid && (
          hit(cur.valid && cur.rw, cur.rd, bus.id_rs) || hit(cur.valid && cur.rw, cur.rd, rt_eff) ||
          hit(bus.exmem_reg_write, bus.exmem_rd, bus.id_rs) || hit(bus.exmem_reg_write, bus.exmem_rd, rt_eff) ||
          hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rs) || hit(bus.memwb_reg_write, bus.memwb_rd, rt_eff));
`endif
      return s && !bus.flush;
   endfunction

   function automatic ent_t capture();
      ent_t c;
      c = bubble_e;
      c.valid = 1'b1; c.rw = bus.id_reg_write; c.mr = bus.id_mem_read;
      c.mw = bus.id_mem_write; c.m2r = bus.id_mem_to_reg; c.alu_src = bus.id_alu_src;
      c.ctrl = (bus.id_alu_ctrl == 3'b010) ? 3'b001 : bus.id_alu_ctrl;
      c.rd = bus.id_rd; c.rs = bus.id_rs; c.rt = bus.id_rt; c.shamt = bus.id_shamt;
      c.imm = bus.id_imm; c.rs_data = bus.id_rs_data; c.rt_data = bus.id_rt_data;
`ifdef ID_EX_FWD_EN
      if (hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rs)) c.rs_data = bus.memwb_result;
      if (hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rt)) c.rt_data = bus.memwb_result;
`endif
      return c;
   endfunction

   function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] stored);
`ifdef ID_EX_FWD_EN
      if (hit(bus.exmem_reg_write, bus.exmem_rd, idx)) return bus.exmem_result;
      if (hit(bus.memwb_reg_write, bus.memwb_rd, idx)) return bus.memwb_result;
`endif
      return stored;
   endfunction

   // One clock: called right after a falling edge with inputs already set.
   task automatic step();
      logic        st;
      ent_t        nx, e;
      logic [31:0] fa, fb, e1, e2;
      #1;
      st = exp_stall();
      check("hazard_stall", 32'(bus.hazard_stall), 32'(st));
      if (bus.hold) nx = cur;
      else if (bus.flush || st || !bus.id_valid) nx = bubble_e;
      else nx = capture();
      sb_q.push_back(nx);
      cur = nx;
      @(posedge clk);
      #1;
      e  = sb_q.pop_front();
      fa = fwd_val(e.rs, e.rs_data);
      fb = fwd_val(e.rt, e.rt_data);
      if (e.ctrl == 3'b101) begin e1 = fb; e2 = {27'd0, e.shamt}; end
      else if (e.alu_src)  begin e1 = fa; e2 = e.imm; end
      else                 begin e1 = fa; e2 = fb; end
      check("ex_flags", 32'({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}),
            32'({e.valid, e.rw, e.mr, e.mw, e.m2r}));
      check("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
      check("alu_ctrl", 32'(bus.alu_ctrl), 32'(e.ctrl));
      check("alu_in1", bus.alu_in1, e1);
      check("alu_in2", bus.alu_in2, e2);
      check("ex_store_data", bus.ex_store_data, fb);
      @(negedge clk);
   endtask

   task automatic lw_r4();
      set_id(1'b1, 3'b001, 5'd2, 5'd0, 5'd4, 32'd100, 32'd0, 32'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      bubble_e = '0;
      cur = bubble_e;
      rst_n = 1'b0;
      bus.flush = 1'b0; bus.hold = 1'b0;
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      set_id(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
      check("rst_alu_in1", bus.alu_in1, 32'd0);
      check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // add r6 = r3 + r5, r3 being written by both later stages
      set_fwd(1'b1, 5'd3, 32'd50, 1'b1, 5'd3, 32'd9);
      set_id(1'b1, 3'b000, 5'd3, 5'd5, 5'd6, 32'd7, 32'd11, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step();
      set_fwd(1'b1, 5'd3, 32'd50, 1'b1, 5'd3, 32'd9);
      bus.hold = 1'b1;
      step();
`ifdef ID_EX_FWD_EN
      check("fwd_exmem_wins", bus.alu_in1, 32'd50);
`else
      check("nofwd_stored_rs", bus.alu_in1, 32'd7);
`endif
      bus.hold = 1'b0;
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // load-use on r4
      lw_r4(); step();
      set_id(1'b1, 3'b000, 5'd4, 5'd5, 5'd8, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 check("load_use_stall", 32'(bus.hazard_stall), 32'd1);
      step();
      check("load_use_bubble", 32'(bus.ex_valid), 32'd0);
      step();
      check("load_use_capture", 32'(bus.ex_rd), 32'd8);
      lw_r4(); step();
      set_id(1'b1, 3'b000, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();

      // sll r7 = r5 << 7
      set_id(1'b1, 3'b101, 5'd0, 5'd5, 5'd7, 32'd0, 32'd4, 32'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("sll_in1", bus.alu_in1, 32'd4);
      check("sll_in2", bus.alu_in2, 32'd7);
      check("sll_ctrl", 32'(bus.alu_ctrl), 32'd5);

      // sw r9, 12(r2) with r9 in EX/MEM
      set_fwd(1'b1, 5'd9, 32'd77, 1'b0, 5'd0, 32'd0);
      set_id(1'b1, 3'b010, 5'd2, 5'd9, 5'd0, 32'd100, 32'd33, 32'd12, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
`ifdef ID_EX_FWD_EN
      check("sw_store_fwd", bus.ex_store_data, 32'd77);
`endif
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step();
      check("sw_ctrl", 32'(bus.alu_ctrl), 32'd1);
      check("sw_in2", bus.alu_in2, 32'd12);
      check("sw_store", bus.ex_store_data, 32'd33);

      // flush, hold, flush+hold
      bus.flush = 1'b1; step(); bus.flush = 1'b0;
      check("flush_bubble", 32'(bus.ex_valid), 32'd0);
      set_id(1'b1, 3'b011, 5'd1, 5'd2, 5'd3, 32'h0000F0F0, 32'h0000FF00, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      bus.hold = 1'b1;
      set_id(1'b1, 3'b100, 5'd6, 5'd7, 5'd9, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      check("hold_in1", bus.alu_in1, 32'h0000F0F0);
      bus.flush = 1'b1; step();
      check("flush_hold_kept", 32'(bus.alu_ctrl), 32'd3);
      bus.flush = 1'b0; bus.hold = 1'b0;

      // flush together with a load-use: bubble, no stall
      lw_r4(); step();
      set_id(1'b1, 3'b000, 5'd4, 5'd5, 5'd8, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      bus.flush = 1'b1; step(); bus.flush = 1'b0;
      bus.id_valid = 1'b0; step();

      // asynchronous reset in the middle of a cycle
      set_id(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ex_valid", 32'(bus.ex_valid), 32'd0);
      check("midrst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
      check("midrst_alu_in1", bus.alu_in1, 32'd0);
      check("midrst_alu_in2", bus.alu_in2, 32'd0);
      check("midrst_stall", 32'(bus.hazard_stall), 32'd0);
      cur = bubble_e;
      @(negedge clk);
      rst_n = 1'b1;

      // random traffic over a small register window
      for (int i = 0; i < 80; i++) begin
         set_id($urandom_range(7, 0) != 0, 3'($urandom_range(7, 0)),
                5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                $urandom, $urandom, $urandom, 5'($urandom_range(31, 0)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
         set_fwd(1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom,
                 1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom);
         bus.flush = ($urandom_range(7, 0) == 0);
         bus.hold  = ($urandom_range(7, 0) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
